// File: rtl/instr_decode_stage.sv
// Registered RISC-V decode stage with a two-entry skid buffer between fetch and register read.
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to flag illegal encodings on out_illegal.
module instr_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  localparam entry_t RESET_ENTRY = '{
    pc:      {XLEN{1'b0}},
    instr:   32'h0000_0000,
    fmt:     FMT_NONE,
    imm:     {XLEN{1'b0}},
    illegal: 1'b0
  };

  function automatic logic [2:0] fmt_of(input logic [6:0] opcode);
    logic [2:0] f;
    case (opcode)
      7'b0110011:                                             f = FMT_R;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: f = FMT_I;
      7'b0100011:                                             f = FMT_S;
      7'b1100011:                                             f = FMT_B;
      7'b0110111, 7'b0010111:                                 f = FMT_U;
      7'b1101111:                                             f = FMT_J;
      default:                                                f = FMT_NONE;
    endcase
    return f;
  endfunction

  function automatic logic [XLEN-1:0] imm_of(input logic [31:0] instr, input logic [2:0] fmt);
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_x;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'h000};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'h0000_0000;
    endcase
    // 32-bit immediate widened by sign so the same code serves XLEN 32 and 64
    imm_x       = {XLEN{imm32[31]}};
    imm_x[31:0] = imm32;
    return imm_x;
  endfunction

  function automatic logic illegal_of(input logic [31:0] instr, input logic [2:0] fmt);
`ifdef DECODE_ILLEGAL_CHECK_EN
    return (instr[1:0] != 2'b11) || (fmt == FMT_NONE);
`else
    return 1'b0 & instr[0] & fmt[0];
`endif
  endfunction

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  entry_t in_entry;
  logic   accept;
  logic   xfer;

  // Combinational decode of the incoming word
  always_comb begin
    in_entry         = RESET_ENTRY;
    in_entry.pc      = in_pc;
    in_entry.instr   = in_instr;
    in_entry.fmt     = fmt_of(in_instr[6:0]);
    in_entry.imm     = imm_of(in_instr, in_entry.fmt);
    in_entry.illegal = illegal_of(in_instr, in_entry.fmt);
  end

  assign accept = in_valid && in_ready_q;
  assign xfer   = out_valid_q && out_ready;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_EMPTY;
      main_q      <= RESET_ENTRY;
      skid_q      <= RESET_ENTRY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and buffer steering; flush drops both buffered and arriving entries
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            main_d  = in_entry;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept && xfer) begin
            state_d = ST_ONE;
            main_d  = in_entry;
          end else if (accept) begin
            state_d = ST_TWO;
            skid_d  = in_entry;
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_ONE;
          end
        end
        ST_TWO: begin
          if (xfer) begin
            state_d = ST_ONE;
            main_d  = skid_q;
          end else begin
            state_d = ST_TWO;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Handshake outputs registered from the next state so in_ready never sees out_ready combinationally
  always_comb begin
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_pc      = main_q.pc;
  assign out_opcode  = main_q.instr[6:0];
  assign out_rd      = main_q.instr[11:7];
  assign out_funct3  = main_q.instr[14:12];
  assign out_rs1     = main_q.instr[19:15];
  assign out_rs2     = main_q.instr[24:20];
  assign out_funct7  = main_q.instr[31:25];
  assign out_fmt     = main_q.fmt;
  assign out_imm     = main_q.imm;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage (XLEN=64): directed test-plan cases plus randomized traffic.
module tb_instr_decode_stage;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [6:0]      out_opcode;
  logic [4:0]      out_rd;
  logic [2:0]      out_funct3;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [6:0]      out_funct7;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_illegal;

  instr_decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7),
    .out_fmt(out_fmt), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: format table and immediates built with signed integer arithmetic
  function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
    exp_t   e;
    longint v;
    longint s;
    e.instr = ins;
    e.pc    = pc;
    case (ins[6:0])
      7'h33:                         e.fmt = 3'd0;
      7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: e.fmt = 3'd1;
      7'h23:                         e.fmt = 3'd2;
      7'h63:                         e.fmt = 3'd3;
      7'h37, 7'h17:                  e.fmt = 3'd4;
      7'h6F:                         e.fmt = 3'd5;
      default:                       e.fmt = 3'd7;
    endcase
    s = ins[31] ? -64'sd1 : 64'sd0;
    case (e.fmt)
      3'd1:    v = longint'($signed(ins)) >>> 20;
      3'd2:    v = (longint'($signed(ins)) >>> 25) * 32 + longint'(ins[11:7]);
      3'd3:    v = s * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                   + longint'(ins[11:8]) * 2;
      3'd4:    v = longint'($signed(ins & 32'hFFFF_F000));
      3'd5:    v = s * 1048576 + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                   + longint'(ins[30:21]) * 2;
      default: v = 0;
    endcase
    e.imm = v;
    e.ill = ILL_EN && ((ins[1:0] != 2'b11) || (e.fmt == 3'd7));
    return e;
  endfunction

  // Monitor: compares the presented entry to the scoreboard head and retires it on transfer
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
    end else begin
      check("out_valid", {63'd0, out_valid}, {63'd0, sbq.size() != 0});
      check("in_ready", {63'd0, in_ready}, {63'd0, sbq.size() < 2});
      if (out_valid && sbq.size() != 0) begin
        mon_e = sbq[0];
        check("pc", out_pc, mon_e.pc);
        check("opcode", {57'd0, out_opcode}, {57'd0, mon_e.instr[6:0]});
        check("rd", {59'd0, out_rd}, {59'd0, mon_e.instr[11:7]});
        check("funct3", {61'd0, out_funct3}, {61'd0, mon_e.instr[14:12]});
        check("rs1", {59'd0, out_rs1}, {59'd0, mon_e.instr[19:15]});
        check("rs2", {59'd0, out_rs2}, {59'd0, mon_e.instr[24:20]});
        check("funct7", {57'd0, out_funct7}, {57'd0, mon_e.instr[31:25]});
        check("fmt", {61'd0, out_fmt}, {61'd0, mon_e.fmt});
        check("imm", out_imm, mon_e.imm);
        check("illegal", {63'd0, out_illegal}, {63'd0, mon_e.ill});
        if (out_ready && !flush) void'(sbq.pop_front());
      end
      if (flush) sbq.delete();
    end
  end

  // One cycle of stimulus; an accepted, unflushed instruction is pushed as expected output
  task automatic cyc(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                     input logic rdy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (in_valid && in_ready && !flush && !reset) sbq.push_back(model(ins, pc));
  endtask

  logic [6:0]  ops [0:10];
  logic [31:0] r;
  logic [31:0] ins_r;
  logic [63:0] pc_r;
  int          k;

  initial begin
    ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 64'h0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_fmt", {61'd0, out_fmt}, 64'd7);
    check("rst_imm", out_imm, 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_opcode", {57'd0, out_opcode}, 64'd0);

    cyc(1'b1, 32'h0050_0093, 64'h1000, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("addi_opcode", {57'd0, out_opcode}, 64'h13);
    check("addi_rd", {59'd0, out_rd}, 64'd1);
    check("addi_rs1", {59'd0, out_rs1}, 64'd0);
    check("addi_fmt", {61'd0, out_fmt}, 64'd1);
    check("addi_imm", out_imm, 64'd5);

    cyc(1'b1, 32'hFE20_AE23, 64'h1004, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("sw_fmt", {61'd0, out_fmt}, 64'd2);
    check("sw_rs1", {59'd0, out_rs1}, 64'd1);
    check("sw_rs2", {59'd0, out_rs2}, 64'd2);
    check("sw_funct3", {61'd0, out_funct3}, 64'd2);
    check("sw_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

    cyc(1'b1, 32'h1234_52B7, 64'h1008, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("lui_fmt", {61'd0, out_fmt}, 64'd4);
    check("lui_rd", {59'd0, out_rd}, 64'd5);
    check("lui_imm", out_imm, 64'h1234_5000);

    cyc(1'b1, 32'h0000_0000, 64'h100C, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("zero_fmt", {61'd0, out_fmt}, 64'd7);
    check("zero_imm", out_imm, 64'd0);
    check("zero_illegal", {63'd0, out_illegal}, {63'd0, ILL_EN});

    // Backpressure: A and B fill the buffer, then drain in order
    cyc(1'b1, 32'h0010_0113, 64'h2000, 1'b0, 1'b0);
    cyc(1'b1, 32'h0020_0193, 64'h2004, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
    check("bp_head_pc", out_pc, 64'h2000);
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("bp_second_pc", out_pc, 64'h2004);
    check("bp_second_valid", {63'd0, out_valid}, 64'd1);
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("bp_drained", {63'd0, out_valid}, 64'd0);

    // Flush while full, with a new instruction offered at the same time
    cyc(1'b1, 32'h0030_0213, 64'h3000, 1'b0, 1'b0);
    cyc(1'b1, 32'h0040_0293, 64'h3004, 1'b0, 1'b0);
    cyc(1'b1, 32'h0050_0313, 64'h3008, 1'b1, 1'b1);
    cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_in_ready", {63'd0, in_ready}, 64'd1);

    for (int i = 0; i < 800; i++) begin
      k = $urandom_range(0, 11);
      r = $urandom;
      ins_r = (k == 11) ? r : {r[31:7], ops[k]};
      pc_r = {$urandom, $urandom};
      cyc(($urandom_range(0, 9) < 7), ins_r, pc_r, ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 99) < 3));
    end

    repeat (4) cyc(1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    check("drain_empty", {32'd0, sbq.size()}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
